instruction_loader: RTL

//  Writer side of the processor's instruction memory. Accepts a byte stream of

---
 rtl/instruction_loader_if.sv | 27 ++
 rtl/instruction_loader.sv | 129 ++++++++++++
 2 files changed

// File: rtl/instruction_loader_if.sv
// Byte-stream input, instruction-memory write port and status of the instruction loader.
interface instruction_loader_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_we;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [ADDR_WIDTH-1:0] prog_len;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, mem_addr, mem_data, mem_we, busy, done, error, prog_len
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, mem_addr, mem_data, mem_we, busy, done, error, prog_len
    );
endinterface

// File: rtl/instruction_loader.sv
// Translates ASCII BF program text into opcodes and writes them into the instruction store,
// terminating with HALT and checking bracket balance and capacity.
module instruction_loader #(
    parameter int DATA_WIDTH  = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 8
) (
    input logic                clk,
    input logic                reset,
    instruction_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = '1;
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_MAX = '1;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [DEPTH_WIDTH-1:0] depth;
    logic                   in_ready_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   error_r;
    logic                   mem_we_r;
    logic [ADDR_WIDTH-1:0]  mem_addr_r;
    logic [DATA_WIDTH-1:0]  mem_data_r;

    logic is_term;
    logic is_cmd;
    logic fault;

    function automatic logic is_bf(input logic [7:0] c);
        return (c == "+") || (c == "-") || (c == ">") || (c == "<") ||
               (c == "[") || (c == "]") || (c == ".") || (c == ",");
    endfunction

    // HALT (0) for the terminator and any non-command byte.
    function automatic logic [3:0] bf_opcode(input logic [7:0] c);
        case (c)
            "+":     return 4'd1;
            "-":     return 4'd2;
            ">":     return 4'd3;
            "<":     return 4'd4;
            "[":     return 4'd5;
            "]":     return 4'd6;
            ".":     return 4'd7;
            ",":     return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    // The last address is kept free so HALT always fits.
    always_comb begin
        is_term = (bus.in_data == 8'h00);
        is_cmd  = is_bf(bus.in_data);
        fault   = 1'b0;
        if (is_term) begin
            fault = (depth != '0);
        end else if (is_cmd) begin
            fault = (wr_ptr == LAST_ADDR) ||
                    ((bus.in_data == "[") && (depth == DEPTH_MAX)) ||
                    ((bus.in_data == "]") && (depth == '0));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            depth      <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= '0;
            mem_data_r <= '0;
        end else begin
            mem_we_r <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (bus.start) begin
                        state      <= LOAD;
                        wr_ptr     <= '0;
                        depth      <= '0;
                        done_r     <= 1'b0;
                        error_r    <= 1'b0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.in_valid && (is_term || is_cmd)) begin
                        if (fault) begin
                            state      <= ERROR;
                            error_r    <= 1'b1;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b0;
                        end else begin
                            mem_we_r   <= 1'b1;
                            mem_addr_r <= wr_ptr;
                            mem_data_r <= DATA_WIDTH'(bf_opcode(bus.in_data));
                            if (is_term) begin
                                state      <= DONE;
                                done_r     <= 1'b1;
                                in_ready_r <= 1'b0;
                                busy_r     <= 1'b0;
                            end else begin
                                wr_ptr <= wr_ptr + 1'b1;
                                if (bus.in_data == "[") depth <= depth + 1'b1;
                                if (bus.in_data == "]") depth <= depth - 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = in_ready_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.error    = error_r;
    assign bus.mem_we   = mem_we_r;
    assign bus.mem_addr = mem_addr_r;
    assign bus.mem_data = mem_data_r;
    assign bus.prog_len = wr_ptr;
endmodule
